// File: rtl/alu_mc.sv
// alu_mc: clocked multi-cycle EX-stage ALU.
// Single-cycle logic ops plus iterative unsigned multiply/divide.
//
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   start           request, sampled only while idle
//   gin[2:0]        ALU control, sampled with start
//   a, b            operands, sampled with start
//   busy            high while a multi-cycle op iterates
//   done            one-cycle pulse when results are valid
//   sum, hi         primary / secondary result (registered)
//   zout            sum == 0 (registered)
//   overflow        arithmetic overflow of the last op
//   dz              divide by zero on the last op
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       gin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] hi,
    output logic             zout,
    output logic             overflow,
    output logic             dz
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int MSB = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mul;
    // r_acc: product high half / partial remainder
    // r_mq : multiplier (shifted out) / dividend->quotient
    // r_m  : multiplicand / divisor
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] r_m;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_hi;
    logic             r_zout;
    logic             r_ovf;
    logic             r_dz;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_slt;

    assign w_add = a + b;
    assign w_sub = a - b;

    // Signs differ: a<b exactly when a is negative, so the
    // (possibly overflowed) difference is only trusted otherwise.
    assign w_slt = (a[MSB] != b[MSB]) ? a[MSB] : w_sub[MSB];

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        unique case (gin)
            OP_AND: w_res = a & b;
            OP_OR:  w_res = a | b;
            OP_NOR: w_res = ~(a | b);
            OP_ADD: begin
                w_res = w_add;
                w_ovf = (a[MSB] == b[MSB]) && (w_add[MSB] != a[MSB]);
            end
            OP_SUB: begin
                w_res = w_sub;
                w_ovf = (a[MSB] != b[MSB]) && (w_sub[MSB] != a[MSB]);
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_MUL: w_res = '0;
            OP_DIV: w_res = '0;
        endcase
    end

    // ---------------- iterative step ----------------
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_dsub;
    logic             w_ge;
    logic [WIDTH-1:0] w_nacc;
    logic [WIDTH-1:0] w_nmq;

    // Multiply: add multiplicand when the current multiplier LSB is
    // set, then shift {carry, acc, mq} right by one.
    assign w_madd = {1'b0, r_acc} + (r_mq[0] ? {1'b0, r_m} : '0);

    // Divide: shift next dividend bit into the remainder and try a
    // subtraction. The remainder stays below the divisor, so the
    // trial needs one extra bit but the difference never does.
    assign w_trial = {r_acc, r_mq[MSB]};
    assign w_ge    = (w_trial >= {1'b0, r_m});
    assign w_dsub  = w_trial[WIDTH-1:0] - r_m;

    always_comb begin
        if (r_mul) begin
            w_nacc = w_madd[WIDTH:1];
            w_nmq  = {w_madd[0], r_mq[WIDTH-1:1]};
        end else begin
            w_nacc = w_ge ? w_dsub : w_trial[WIDTH-1:0];
            w_nmq  = {r_mq[WIDTH-2:0], w_ge};
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mul   <= 1'b0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_m     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_hi    <= '0;
            r_zout  <= 1'b1;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (gin == OP_MUL ||
                            (gin == OP_DIV && b != '0)) begin
                            r_state <= S_CALC;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_mul   <= (gin == OP_MUL);
                            r_acc   <= '0;
                            r_mq    <= (gin == OP_MUL) ? b : a;
                            r_m     <= (gin == OP_MUL) ? a : b;
                        end else if (gin == OP_DIV) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_sum   <= '1;
                            r_hi    <= a;
                            r_zout  <= 1'b0;
                            r_ovf   <= 1'b0;
                            r_dz    <= 1'b1;
                        end else begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                            r_sum   <= w_res;
                            r_hi    <= '0;
                            r_zout  <= ~|w_res;
                            r_ovf   <= w_ovf;
                            r_dz    <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_nacc;
                    r_mq  <= w_nmq;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_nmq;
                        r_hi    <= w_nacc;
                        r_zout  <= ~|w_nmq;
                        r_ovf   <= r_mul && (w_nacc != '0);
                        r_dz    <= 1'b0;
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign hi       = r_hi;
    assign zout     = r_zout;
    assign overflow = r_ovf;
    assign dz       = r_dz;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized self-checking bench for alu_mc.
// Reference model uses wide integer arithmetic and latency counts.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   gin = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, zout, overflow, dz;
    logic [W-1:0] sum, hi;

    logic         start8 = 1'b0;
    logic [2:0]   gin8 = '0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         busy8, done8, zout8, ovf8, dz8;
    logic [7:0]   sum8, hi8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .gin(gin),
        .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
        .hi(hi), .zout(zout), .overflow(overflow), .dz(dz)
    );

    alu_mc #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .gin(gin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .hi(hi8), .zout(zout8), .overflow(ovf8), .dz(dz8)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference result of one operation, from plain arithmetic.
    function automatic void ref_op(input logic [2:0] g,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   output logic [W-1:0] s,
                                   output logic [W-1:0] h,
                                   output logic o, output logic d);
        longint r;
        logic [W-1:0] lo;
        logic [63:0] p;
        s = '0; h = '0; o = 1'b0; d = 1'b0;
        case (g)
            3'd0: s = x & y;
            3'd1: s = x | y;
            3'd5: s = ~(x | y);
            3'd2, 3'd6: begin
                longint sx = $signed(x);
                longint sy = $signed(y);
                r = (g == 3'd2) ? sx + sy : sx - sy;
                lo = r[W-1:0];
                s = lo;
                o = (r != longint'($signed(lo)));
            end
            3'd7: s = ($signed(x) < $signed(y)) ? 1 : 0;
            3'd3: begin
                p = 64'(x) * 64'(y);
                s = p[W-1:0];
                h = p[63:W];
                o = (h != 0);
            end
            default: begin
                if (y == 0) begin
                    s = '1; h = x; d = 1'b1;
                end else begin
                    s = x / y; h = x % y;
                end
            end
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    int           cl = 0;
    bit           m_busy = 0, m_done = 0;
    logic [W-1:0] e_sum = '0, e_hi = '0, p_sum, p_hi;
    logic         e_ovf = 0, e_dz = 0, p_ovf, p_dz;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cl = 0; m_busy = 0; m_done = 0;
            e_sum = '0; e_hi = '0; e_ovf = 0; e_dz = 0;
        end else if (m_busy) begin
            cl--;
            if (cl == 0) begin
                m_busy = 0; m_done = 1;
                e_sum = p_sum; e_hi = p_hi; e_ovf = p_ovf; e_dz = p_dz;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            ref_op(gin, a, b, p_sum, p_hi, p_ovf, p_dz);
            if (gin == 3'd3 || (gin == 3'd4 && b != 0)) begin
                cl = W; m_busy = 1;
            end else begin
                m_done = 1;
                e_sum = p_sum; e_hi = p_hi; e_ovf = p_ovf; e_dz = p_dz;
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 64'(busy), 64'(m_busy));
        chk("done", 64'(done), 64'(m_done));
        chk("sum", 64'(sum), 64'(e_sum));
        chk("hi", 64'(hi), 64'(e_hi));
        chk("zout", 64'(zout), 64'(e_sum == 0));
        chk("overflow", 64'(overflow), 64'(e_ovf));
        chk("dz", 64'(dz), 64'(e_dz));
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] g, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(posedge clk); #2;
        start = 1'b1; gin = g; a = x; b = y;
        @(posedge clk); #2;
        start = 1'b0;
        a = $urandom; b = $urandom; gin = 3'($urandom);
    endtask

    // Waits for done; optionally pulses a stray start at cycle noise_at.
    task automatic wait_done(input int noise_at, output int lat,
                             output int nb);
        bit got = 0;
        lat = 0; nb = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) nb++;
            if (done) got = 1;
            else if (lat == noise_at) begin
                start = 1'b1; gin = 3'd4; a = $urandom; b = 1;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=%0d required=<200", lat);
        end
    endtask

    task automatic run(input logic [2:0] g, input logic [W-1:0] x,
                       input logic [W-1:0] y, output int lat,
                       output int nb);
        issue(g, x, y);
        wait_done(-1, lat, nb);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    int lat, nb, n8;

    initial begin
        repeat (2) @(posedge clk);
        #3;
        chk("rst_zout", 64'(zout), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        #0 reset = 1'b0;

        // add overflow
        run(3'b010, 32'h7FFF_FFFF, 32'd1, lat, nb);
        chk("add_sum", 64'(sum), 64'h8000_0000);
        chk("add_ovf", 64'(overflow), 64'd1);
        chk("add_zout", 64'(zout), 64'd0);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_nobusy", 64'(nb), 64'd0);

        // slt across overflow
        run(3'b111, 32'h8000_0000, 32'd1, lat, nb);
        chk("slt1_sum", 64'(sum), 64'd1);
        run(3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, lat, nb);
        chk("slt2_sum", 64'(sum), 64'd0);
        chk("slt2_zout", 64'(zout), 64'd1);

        // mulu
        run(3'b011, 32'h0001_0000, 32'h0001_0000, lat, nb);
        chk("mul_hi", 64'(hi), 64'd1);
        chk("mul_sum", 64'(sum), 64'd0);
        chk("mul_ovf", 64'(overflow), 64'd1);
        chk("mul_zout", 64'(zout), 64'd1);
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_busy", 64'(nb), 64'd32);
        run(3'b011, 32'd6, 32'd7, lat, nb);
        chk("mul67_sum", 64'(sum), 64'd42);
        chk("mul67_hi", 64'(hi), 64'd0);
        chk("mul67_ovf", 64'(overflow), 64'd0);

        // divu
        run(3'b100, 32'd100, 32'd7, lat, nb);
        chk("div_sum", 64'(sum), 64'd14);
        chk("div_hi", 64'(hi), 64'd2);
        chk("div_dz", 64'(dz), 64'd0);
        chk("div_lat", 64'(lat), 64'd33);
        run(3'b100, 32'd9, 32'd0, lat, nb);
        chk("dz_sum", 64'(sum), 64'hFFFF_FFFF);
        chk("dz_hi", 64'(hi), 64'd9);
        chk("dz_dz", 64'(dz), 64'd1);
        chk("dz_lat", 64'(lat), 64'd1);

        // stray start during CALC is ignored
        issue(3'b011, 32'd1234, 32'd5678);
        wait_done(5, lat, nb);
        chk("hs_sum", 64'(sum), 64'd7006652);
        chk("hs_hi", 64'(hi), 64'd0);
        chk("hs_lat", 64'(lat), 64'd33);
        repeat (3) begin
            @(negedge clk);
            chk("hs_extra_done", 64'(done), 64'd0);
        end

        // reset in the middle of a multiply
        issue(3'b011, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_sum", 64'(sum), 64'd0);
        chk("mid_hi", 64'(hi), 64'd0);
        chk("mid_zout", 64'(zout), 64'd1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        run(3'b010, 32'd5, 32'd3, lat, nb);
        chk("post_rst_sum", 64'(sum), 64'd8);

        // 8-bit instance
        @(posedge clk); #2;
        start8 = 1'b1; gin8 = 3'b010; a8 = 8'h7F; b8 = 8'h01;
        @(posedge clk); #2;
        start8 = 1'b0;
        @(negedge clk);
        chk("w8_done", 64'(done8), 64'd1);
        chk("w8_sum", 64'(sum8), 64'h80);
        chk("w8_ovf", 64'(ovf8), 64'd1);
        @(posedge clk); #2;
        start8 = 1'b1; gin8 = 3'b010; a8 = 8'hFF; b8 = 8'h01;
        @(posedge clk); #2;
        start8 = 1'b0;
        @(negedge clk);
        chk("w8b_sum", 64'(sum8), 64'h00);
        chk("w8b_zout", 64'(zout8), 64'd1);
        chk("w8b_ovf", 64'(ovf8), 64'd0);
        @(posedge clk); #2;
        start8 = 1'b1; gin8 = 3'b011; a8 = 8'd15; b8 = 8'd17;
        @(posedge clk); #2;
        start8 = 1'b0;
        n8 = 0;
        do begin
            @(negedge clk);
            n8++;
        end while (!done8 && n8 < 50);
        chk("w8m_lat", 64'(n8), 64'd9);
        chk("w8m_sum", 64'(sum8), 64'hFF);
        chk("w8m_hi", 64'(hi8), 64'h00);

        // randomized operations against the model
        for (int i = 0; i < 80; i++) begin
            int na;
            na = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
            issue(3'($urandom_range(0, 7)), pick(), pick());
            wait_done(na, lat, nb);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, clocked, multi-cycle successor to the datapath's single-cycle 32-bit ALU.
- Keeps the existing 3-bit ALU control encoding for add, sub, slt, and, or.
- Adds iterative unsigned multiply, unsigned divide and nor.
- Adds a start/busy/done handshake so the control unit can stall the pipeline during multi-cycle operations.
- Sits in the EX stage; results and flags are registered.

Parameters:
- WIDTH, 32: operand and result width in bits (≥4).
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- gin  input  3  ALU control line, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum/hi/flags are valid
- sum  output  WIDTH  primary result (product low half, quotient)
- hi  output  WIDTH  product high half or remainder; 0 for other ops
- zout  output  1  high when sum == 0
- overflow  output  1  arithmetic overflow for the last op
- dz  output  1  divide by zero occurred on the last op

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, sum=0, hi=0, zout=1, overflow=0, dz=0.
- Reset mid-operation: aborts immediately, no done pulse, all outputs return to reset values.
- States: IDLE, CALC, FIN.
  - IDLE: if start=1, latch gin/a/b.
    - Single-cycle op: compute and go to FIN.
    - 011 or 100 with b≠0: go to CALC, busy=1, count=0.
    - 100 with b=0: go to FIN.
  - CALC: one iteration per cycle. After WIDTH iterations (count==WIDTH-1), go to FIN.
  - FIN: done=1 for exactly this cycle, busy=0, registered outputs updated. Next state is IDLE.
  - FIN does not accept start. start is sampled only in IDLE, so back-to-back ops have at least one IDLE cycle between done and the next start.
- Latency, counted from the start-sampling edge:
  - Single-cycle ops and divide-by-zero: done is high in the following cycle.
  - Multiply and divide: done is high WIDTH+1 cycles after the sampling edge.
- busy timing: high from the cycle after start sampling through the last CALC cycle; low in FIN. busy is not asserted for single-cycle ops.
- start in CALC or FIN is ignored; no queueing.
- sum, hi and all flags hold their last value until the next done. Operand changes after sampling have no effect.
- Operations (gin):
  - 010 add: sum=a+b mod 2^WIDTH; overflow = signed overflow (a[MSB]==b[MSB] && sum[MSB]!=a[MSB]).
  - 110 sub: sum=a-b; overflow = (a[MSB]!=b[MSB] && sum[MSB]!=a[MSB]).
  - 111 slt: sum=1 if a<b as signed two's-complement, else 0. The comparison must be correct even when a-b overflows. overflow=0.
  - 000 and, 001 or, 101 nor (~(a|b)): overflow=0.
  - 011 mulu: unsigned shift-add, one bit of b per cycle, LSB first. {hi,sum} = a*b, 2·WIDTH-bit product. overflow = (hi≠0).
  - 100 divu: unsigned restoring division, one quotient bit per cycle, MSB first. sum=quotient, hi=remainder, overflow=0.
    - b=0: sum = all ones, hi = a, dz=1, single-cycle latency.
- hi=0 for all ops except mulu and divu.
- dz=0 for every op except divu with b=0.
- zout = ~|sum, evaluated on the registered result. It ignores hi.
- All 8 gin codes are defined; there is no x output.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert reset mid-mulu (a=3, b=5, cycle 10 of CALC) → outputs immediately reset values, zout=1, no done. After release, state is IDLE and start is accepted.
- add overflow: a=0x7FFF_FFFF, b=1, gin=010 → next cycle done=1, sum=0x8000_0000, overflow=1, zout=0, busy never high.
- slt across overflow: a=0x8000_0000, b=1, gin=111 → sum=1. Then a=0x7FFF_FFFF, b=0xFFFF_FFFF → sum=0, zout=1.
- mulu: a=0x0001_0000, b=0x0001_0000, gin=011 → busy for 32 cycles, done 33 cycles after start, hi=1, sum=0, overflow=1, zout=1. Also a=6, b=7 → sum=42, hi=0, overflow=0.
- divu: a=100, b=7, gin=100 → done at cycle 33, sum=14, hi=2, dz=0. Then b=0, a=9 → next cycle done, sum=0xFFFF_FFFF, hi=9, dz=1.
- Handshake: pulse start with gin=100 during CALC of a running mulu → ignored, mulu result intact. Single done pulse per accepted op. Also repeat one add with WIDTH=8 (8-bit operands) to confirm parametrisation.
